// File: rtl/rtm_pkg.sv
// Shared types and sizing helpers for the racetrack-memory timing model.
package rtm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } rtm_state_e;

    localparam int DATA_W = 32;
    localparam int WE_W   = 4;

    function automatic int dom_w(input int domains);
        return $clog2(domains);
    endfunction

    // One spare bit so dist*SHIFT_CYCLES at the maximum distance never overflows.
    function automatic int sh_cnt_w(input int domains, input int shift_cycles);
        return $clog2(domains) + $clog2(shift_cycles) + 1;
    endfunction

    function automatic int req_w(input int addr_width);
        return WE_W + (addr_width - 2) + DATA_W;
    endfunction

    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

endpackage

// File: rtl/rtm_mem_model_if.sv
// Controller-side request port of the RTM model: en/we/addr/din in, wrready/dout back.
interface rtm_mem_model_if #(
    parameter int ADDR_WIDTH = 10
);
    logic                  en;
    logic [3:0]            we;
    logic [ADDR_WIDTH-3:0] addr;
    logic [31:0]           din;
    logic                  wrready;
    logic [31:0]           dout;

    modport master (output en, we, addr, din, input wrready, dout);
    modport slave  (input en, we, addr, din, output wrready, dout);
endinterface

// File: rtl/rtm_shift_timer.sv
// Head-to-target distance and shift-phase down counter for the RTM model.
module rtm_shift_timer
    import rtm_pkg::*;
#(
    parameter int  DOMAINS      = 16,
    parameter int  SHIFT_CYCLES = 1,
    localparam int DOM_W        = dom_w(DOMAINS),
    localparam int SH_CNT_W     = sh_cnt_w(DOMAINS, SHIFT_CYCLES)
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [DOM_W-1:0] head_i,
    input  logic [DOM_W-1:0] target_i,
    input  logic             load_i,
    input  logic             dec_i,
    output logic [DOM_W-1:0] dist_o,
    output logic             last_o
);

    logic [SH_CNT_W-1:0] sh_cnt_q;
    logic [SH_CNT_W-1:0] sh_cnt_d;
    logic [DOM_W-1:0]    dist_s;

    // Linear distance: the head travels along the track and never wraps.
    always_comb begin
        if (target_i >= head_i) begin
            dist_s = target_i - head_i;
        end else begin
            dist_s = head_i - target_i;
        end
    end

    // Load the shift budget on a new request, count it down while shifting.
    always_comb begin
        sh_cnt_d = sh_cnt_q;
        if (load_i) begin
            sh_cnt_d = SH_CNT_W'(dist_s) * SH_CNT_W'(SHIFT_CYCLES);
        end else if (dec_i) begin
            sh_cnt_d = sh_cnt_q - {{(SH_CNT_W-1){1'b0}}, 1'b1};
        end else begin
            sh_cnt_d = sh_cnt_q;
        end
    end

    // Shift counter register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sh_cnt_q <= {SH_CNT_W{1'b0}};
        end else begin
            sh_cnt_q <= sh_cnt_d;
        end
    end

    assign dist_o = dist_s;
    assign last_o = (sh_cnt_q == {{(SH_CNT_W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/rtm_mem_model.sv
// Racetrack-memory timing model behind the AXI4-Lite controller's request port.
// Optional macro RTM_SHIFT_STATS_EN adds saturating shift_count/access_count outputs.
module rtm_mem_model
    import rtm_pkg::*;
#(
    parameter int ADDR_WIDTH   = 10,
    parameter int DOMAINS      = 16,
    parameter int SHIFT_CYCLES = 1,
    parameter int ACCESS_LAT   = 1
) (
    input  logic          s_aclk,
    input  logic          s_aresetn,
    rtm_mem_model_if.slave bus
`ifdef RTM_SHIFT_STATS_EN
    ,
    output logic [31:0]   shift_count,
    output logic [31:0]   access_count
`endif
);

    localparam int WA    = ADDR_WIDTH - 2;
    localparam int DEPTH = 1 << WA;
    localparam int DOM_W = dom_w(DOMAINS);
    localparam int ACC_W = $clog2(ACCESS_LAT + 1);
    localparam int RQ_W  = req_w(ADDR_WIDTH);

    rtm_state_e        state_q;
    logic [DOM_W-1:0]  head_q;
    logic [RQ_W-1:0]   rl_q;
    logic [ACC_W-1:0]  acc_cnt_q;
    logic [31:0]       dout_q;
    logic [31:0]       mem_q [DEPTH];

    logic [RQ_W-1:0]   req_s;
    logic [3:0]        rl_we_s;
    logic [WA-1:0]     rl_addr_s;
    logic [31:0]       rl_din_s;
    logic [DOM_W-1:0]  dist_s;
    logic              sh_last_s;
    logic              acc_last_s;
    logic              mem_wr_s;
    logic              wrready_s;
    logic              start_s;

    assign req_s     = {bus.we, bus.addr, bus.din};
    assign rl_we_s   = rl_q[RQ_W-1 -: WE_W];
    assign rl_addr_s = rl_q[DATA_W +: WA];
    assign rl_din_s  = rl_q[DATA_W-1:0];

    assign start_s    = (state_q == ST_IDLE) && bus.en;
    assign acc_last_s = (acc_cnt_q == ACC_W'(1));
    assign mem_wr_s   = (state_q == ST_ACCESS) && acc_last_s && (rl_we_s != 4'h0);

    // Completion must fall in the same cycle the controller changes or drops its request.
    assign wrready_s  = (state_q == ST_DONE) && bus.en && (req_s == rl_q);

    rtm_shift_timer #(
        .DOMAINS      (DOMAINS),
        .SHIFT_CYCLES (SHIFT_CYCLES)
    ) u_shift_timer (
        .clk_i    (s_aclk),
        .rst_n_i  (s_aresetn),
        .head_i   (head_q),
        .target_i (bus.addr[DOM_W-1:0]),
        .load_i   (start_s),
        .dec_i    (state_q == ST_SHIFT),
        .dist_o   (dist_s),
        .last_o   (sh_last_s)
    );

    // Request FSM: latch, shift the head, access, then hold completion.
    always_ff @(posedge s_aclk or negedge s_aresetn) begin
        if (!s_aresetn) begin
            state_q   <= ST_IDLE;
            head_q    <= {DOM_W{1'b0}};
            rl_q      <= {RQ_W{1'b0}};
            acc_cnt_q <= {ACC_W{1'b0}};
            dout_q    <= 32'h0000_0000;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.en) begin
                        rl_q      <= req_s;
                        acc_cnt_q <= ACC_W'(ACCESS_LAT);
                        if (dist_s == {DOM_W{1'b0}}) begin
                            state_q <= ST_ACCESS;
                        end else begin
                            state_q <= ST_SHIFT;
                        end
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    if (sh_last_s) begin
                        head_q  <= rl_addr_s[DOM_W-1:0];
                        state_q <= ST_ACCESS;
                    end else begin
                        state_q <= ST_SHIFT;
                    end
                end
                ST_ACCESS: begin
                    acc_cnt_q <= acc_cnt_q - ACC_W'(1);
                    if (acc_last_s) begin
                        if (rl_we_s == 4'h0) begin
                            dout_q <= mem_q[rl_addr_s];
                        end else begin
                            dout_q <= dout_q;
                        end
                        state_q <= ST_DONE;
                    end else begin
                        state_q <= ST_ACCESS;
                    end
                end
                ST_DONE: begin
                    if (wrready_s) begin
                        state_q <= ST_DONE;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Storage has no reset so its contents survive a controller reset.
    always_ff @(posedge s_aclk) begin
        if (mem_wr_s) begin
            for (int b = 0; b < 4; b++) begin
                if (rl_we_s[b]) begin
                    mem_q[rl_addr_s][8*b +: 8] <= rl_din_s[8*b +: 8];
                end
            end
        end
    end

`ifdef RTM_SHIFT_STATS_EN
    logic [31:0] shift_count_q;
    logic [31:0] access_count_q;

    // Saturating counters of head movement and completed accesses.
    always_ff @(posedge s_aclk or negedge s_aresetn) begin
        if (!s_aresetn) begin
            shift_count_q  <= 32'h0000_0000;
            access_count_q <= 32'h0000_0000;
        end else begin
            if (start_s && (dist_s != {DOM_W{1'b0}})) begin
                shift_count_q <= sat_add32(shift_count_q, 32'(dist_s));
            end
            if ((state_q == ST_ACCESS) && acc_last_s) begin
                access_count_q <= sat_add32(access_count_q, 32'h0000_0001);
            end
        end
    end

    assign shift_count  = shift_count_q;
    assign access_count = access_count_q;
`endif

    assign bus.wrready = wrready_s;
    assign bus.dout    = dout_q;

endmodule

// File: doc/rtm_mem_model.md
Name: rtm_mem_model

Overview:
- Racetrack-memory (RTM) timing model sitting directly downstream of the AXI4-Lite memory controller.
- Consumes the controller's en/we/addr/din request port and returns wrready/dout.
- Words live in tracks of DOMAINS positions sharing one global access head. An access costs shift time proportional to head-to-target distance plus a fixed access latency.
- Holds a request complete (wrready high) until the controller moves on.

Parameters:
- ADDR_WIDTH, 10: byte address width on the AXI side; word address is ADDR_WIDTH-2 bits.
- DOMAINS, 16: domains per track, power of 2, at least 2. Domain index = low log2(DOMAINS) bits of the word address; track = remaining upper bits.
- SHIFT_CYCLES, 1: cycles per single-position head shift, at least 1.
- ACCESS_LAT, 1: cycles spent in ACCESS, at least 1.

Ports:
- s_aclk  in  1  clock
- s_aresetn  in  1  asynchronous active-low reset
- en  in  1  request present
- we  in  4  byte write enables; 0 = read
- addr  in  ADDR_WIDTH-2  word address
- din  in  32  write data
- wrready  out  1  current request completed
- dout  out  32  read data of last completed read

Behaviour:
- Interface: one clock s_aclk; reset s_aresetn is asynchronous, active-low.
- Reset values: state=IDLE, head=0, wrready=0, dout=0, latched request=0. The memory array is not reset; its contents survive reset.
- Request tuple R = {we, addr, din}, sampled combinationally. The controller holds R stable and en high until it observes completion.
- States:
  - IDLE: if en, latch R into Rl. dist = |dom(addr) - head|, linear, no wrap. If dist=0 go to ACCESS with acc_cnt=ACCESS_LAT, else go to SHIFT with sh_cnt=dist*SHIFT_CYCLES. If !en, stay.
  - SHIFT: decrement sh_cnt. When sh_cnt=1, set head<=dom(Rl.addr) and go to ACCESS with acc_cnt=ACCESS_LAT.
  - ACCESS: decrement acc_cnt. In the cycle acc_cnt=1, perform the operation, then go to DONE.
    - Write (Rl.we!=0): update only bytes with we[i]=1.
    - Read: dout<=mem[Rl.addr].
  - DONE: wrready = en & (R==Rl), combinational. If !en or R!=Rl, go to IDLE next cycle.
- wrready must be combinational so it drops in the same cycle the controller advances its queue; the controller registers it.
- Latency, request first seen in IDLE at cycle T: wrready high at T + 1 + dist*SHIFT_CYCLES + ACCESS_LAT.
  - Example: dist=0, ACCESS_LAT=1 gives wrready at T+2.
- dout changes only at the ACCESS step of a read; writes leave dout unchanged. dout is stable throughout DONE.
- Boundaries:
  - Request changes or en drops during SHIFT/ACCESS: the latched op still completes (write committed, head moved), then DONE sees a mismatch and returns to IDLE.
  - Back-to-back identical requests (same R): DONE keeps wrready high and no new access occurs. This is acceptable: reads return the same data, writes are idempotent.
  - dist = DOMAINS-1 (max): sh_cnt width is log2(DOMAINS) + log2(SHIFT_CYCLES) + 1 bits; no overflow allowed.
  - Reset asserted mid-operation: immediate return to IDLE, head=0, wrready=0. A partially timed write is not committed.

Optional Feature:
- Macro: RTM_SHIFT_STATS_EN.
- Defined: adds outputs shift_count[31:0] and access_count[31:0], both reset to 0.
  - shift_count increments by dist when leaving IDLE for SHIFT.
  - access_count increments by 1 per ACCESS operation.
  - Both saturate at 32'hFFFFFFFF.
- Undefined: ports and counters are absent; timing is otherwise identical.

Decomposition:
- Package rtm_pkg contains:
  - state encoding: IDLE, SHIFT, ACCESS, DONE;
  - localparam functions DOM_W=$clog2(DOMAINS) and SH_CNT_W;
  - request-tuple width constant.
- Sub-module rtm_shift_timer: computes dist from head and target domain, loads and down-counts sh_cnt, and flags the last cycle. The top module keeps the FSM, memory array and stats.

Test Plan:
- Reset, then read addr 0 (head 0, dist 0, defaults) -> wrready at T+2, dout=0 or memory contents; head stays 0.
- Write we=4'hF addr=5 din=32'hDEADBEEF, then read addr 5 -> write wrready at T+7 (dist 5), read wrready at T+2, dout=32'hDEADBEEF.
- Write we=4'b0101 din=32'h11223344 to a word holding 32'hAABBCCDD, then read -> dout=32'hAA22CC44.
- SHIFT_CYCLES=2, head=15 (DOMAINS=16), read addr 0 -> wrready at T+1+30+1=T+32; with RTM_SHIFT_STATS_EN, shift_count increases by 15.
- In DONE, change addr in the same cycle wrready is sampled -> wrready drops combinationally that cycle; FSM is IDLE the next cycle; new request completes per latency rule.
- Assert s_aresetn=0 during SHIFT of a write -> wrready=0 and dout=0 immediately; head=0; subsequent read of that address returns the old contents.
